// File: rtl/io_pkg.sv
// Shared constants for the peripheral I/O port: register offsets and STATUS bit layout.
package io_pkg;

  localparam logic [1:0] IO_STATUS = 2'b00;
  localparam logic [1:0] IO_SW_LO  = 2'b01;
  localparam logic [1:0] IO_SW_HI  = 2'b10;
  localparam logic [1:0] IO_LED    = 2'b11;

  localparam int SW_READY_BIT  = 1;
  localparam int LED_READY_BIT = 0;

endpackage

// File: rtl/io_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, stable-level debounce counter and
// a one-cycle pulse on each rising edge of the debounced level.
module io_btn_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse
);

  logic        sync1;
  logic        sync2;
  logic        level_dly;
  logic [19:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Any sample that agrees with the accepted level restarts the stability count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= 20'd0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= 20'd0;
    end else if (cnt == DEBOUNCE_CYCLES - 20'd1) begin
      cnt   <= 20'd0;
      level <= ~level;
    end else begin
      cnt <= cnt + 20'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_dly <= 1'b0;
    end else begin
      level_dly <= level;
    end
  end

  assign rise_pulse = level & ~level_dly;

endmodule

// File: rtl/io_port_ctrl.sv
// Memory-mapped button/switch/LED peripheral: captures switches on btnR, commits
// the pending LED value on btnL, and reports both events through a polled STATUS word.
module io_port_ctrl
  import io_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
  parameter int          SW_W            = 16,
  parameter int          LED_W           = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pRead,
  input  logic             pWrite,
  input  logic [1:0]       addr,
  input  logic [31:0]      writeData,
  output logic [31:0]      readData,
  input  logic             btnL,
  input  logic             btnR,
  input  logic [SW_W-1:0]  switch,
  output logic [LED_W-1:0] led
);

  logic             pL;
  logic             pR;
  logic             l_level;
  logic             r_level;
  logic [SW_W-1:0]  sw_sync1;
  logic [SW_W-1:0]  sw_sync2;
  logic [SW_W-1:0]  sw_reg;
  logic [LED_W-1:0] led_pend;
  logic             sw_ready;
  logic             led_ready;
  logic             led_write;
  logic             unused_bits;

  io_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_l (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btnL),
    .level      (l_level),
    .rise_pulse (pL)
  );

  io_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_r (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btnR),
    .level      (r_level),
    .rise_pulse (pR)
  );

  assign led_write   = pWrite && (addr == IO_LED);
  assign unused_bits = ^{writeData[31:LED_W], l_level, r_level};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_sync1 <= '0;
      sw_sync2 <= '0;
    end else begin
      sw_sync1 <= switch;
      sw_sync2 <= sw_sync1;
    end
  end

  // A capture in the same cycle as an SW_HI read keeps the ready flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_reg   <= '0;
      sw_ready <= 1'b0;
    end else if (pR) begin
      sw_reg   <= sw_sync2;
      sw_ready <= 1'b1;
    end else if (pRead && (addr == IO_SW_HI)) begin
      sw_ready <= 1'b0;
    end
  end

  // A commit in the same cycle as an LED write shows the old pending value,
  // and the write's clear of led_ready takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led       <= '0;
      led_pend  <= '0;
      led_ready <= 1'b0;
    end else begin
      if (pL) begin
        led <= led_pend;
      end
      if (led_write) begin
        led_pend  <= writeData[LED_W-1:0];
        led_ready <= 1'b0;
      end else if (pL) begin
        led_ready <= 1'b1;
      end
    end
  end

  always_comb begin
    readData = 32'd0;
    case (addr)
      IO_STATUS: begin
        readData[SW_READY_BIT]  = sw_ready;
        readData[LED_READY_BIT] = led_ready;
      end
      IO_SW_LO: readData = {24'd0, sw_reg[7:0]};
      IO_SW_HI: readData = {24'd0, sw_reg[15:8]};
      IO_LED:   readData = {{(32-LED_W){1'b0}}, led_pend};
      default:  readData = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl with a 4-cycle debounce window.
module tb_io_port_ctrl;
  import io_pkg::*;

  logic        clk;
  logic        reset;
  logic        pRead;
  logic        pWrite;
  logic [1:0]  addr;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        btnL;
  logic        btnR;
  logic [15:0] switch;
  logic [11:0] led;

  int compared;
  int mismatched;
  logic [31:0] rd;

  io_port_ctrl #(.DEBOUNCE_CYCLES(20'd4), .SW_W(16), .LED_W(12)) dut (
    .clk       (clk),
    .reset     (reset),
    .pRead     (pRead),
    .pWrite    (pWrite),
    .addr      (addr),
    .writeData (writeData),
    .readData  (readData),
    .btnL      (btnL),
    .btnR      (btnR),
    .switch    (switch),
    .led       (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic l, input logic r, input logic [15:0] sw);
    btnL   = l;
    btnR   = r;
    switch = sw;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = readData;
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    addr      = a;
    writeData = d;
    pWrite    = 1'b1;
    waitCycles(1);
    pWrite    = 1'b0;
  endtask

  task automatic busRead(input logic [1:0] a, output logic [31:0] v);
    addr  = a;
    pRead = 1'b1;
    #1;
    v = readData;
    waitCycles(1);
    pRead = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    pRead      = 1'b0;
    pWrite     = 1'b0;
    addr       = IO_STATUS;
    writeData  = 32'd0;
    applyStimulus(1'b0, 1'b0, 16'h0000);
    waitCycles(3);
    reset = 1'b0;

    // 1. reset state, then reset asserted mid-operation
    peek(IO_STATUS, rd); checkOutput("status_after_reset", rd, 32'h0);
    peek(IO_LED, rd);    checkOutput("pend_after_reset", rd, 32'h0);
    checkOutput("led_after_reset", {20'd0, led}, 32'h0);
    busWrite(IO_LED, 32'h0000_0123);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    waitCycles(8);
    checkOutput("led_commit_pre_reset", {20'd0, led}, 32'h123);
    applyStimulus(1'b1, 1'b1, 16'h0000);
    waitCycles(3);
    reset = 1'b1;
    peek(IO_STATUS, rd); checkOutput("status_async_reset", rd, 32'h0);
    peek(IO_LED, rd);    checkOutput("pend_async_reset", rd, 32'h0);
    checkOutput("led_async_reset", {20'd0, led}, 32'h0);
    waitCycles(10);
    peek(IO_STATUS, rd); checkOutput("status_held_in_reset", rd, 32'h0);
    checkOutput("led_held_in_reset", {20'd0, led}, 32'h0);
    waitCycles(1);
    reset = 1'b0;
    waitCycles(6);
    peek(IO_STATUS, rd); checkOutput("status_post_reset_early", rd, 32'h0);
    waitCycles(1);
    peek(IO_STATUS, rd); checkOutput("status_post_reset_pulse", rd, 32'h3);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    waitCycles(8);
    busRead(IO_SW_HI, rd);
    busWrite(IO_LED, 32'h0);
    peek(IO_STATUS, rd); checkOutput("status_cleared", rd, 32'h0);

    // 2. switch capture latency and SW_HI read clear
    applyStimulus(1'b0, 1'b0, 16'hA55A);
    waitCycles(3);
    applyStimulus(1'b0, 1'b1, 16'hA55A);
    waitCycles(6);
    peek(IO_STATUS, rd); checkOutput("sw_ready_cycle6", rd, 32'h0);
    waitCycles(1);
    peek(IO_STATUS, rd); checkOutput("sw_ready_cycle7", rd, 32'h2);
    waitCycles(3);
    applyStimulus(1'b0, 1'b0, 16'hA55A);
    waitCycles(8);
    peek(IO_SW_LO, rd);  checkOutput("sw_lo", rd, 32'h5A);
    peek(IO_STATUS, rd); checkOutput("sw_lo_keeps_ready", rd, 32'h2);
    busRead(IO_SW_HI, rd); checkOutput("sw_hi", rd, 32'hA5);
    peek(IO_STATUS, rd); checkOutput("sw_hi_clears_ready", rd, 32'h0);

    // 3. bouncing btnR never captures
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 16'h1234);
      waitCycles(2);
      applyStimulus(1'b0, 1'b0, 16'h1234);
      waitCycles(2);
    end
    waitCycles(8);
    peek(IO_STATUS, rd); checkOutput("bounce_status", rd, 32'h0);
    peek(IO_SW_LO, rd);  checkOutput("bounce_sw_lo", rd, 32'h5A);

    // 4. LED write then commit
    busWrite(IO_LED, 32'hFFFF_F3C5);
    peek(IO_LED, rd); checkOutput("led_pend_write", rd, 32'h3C5);
    checkOutput("led_unchanged", {20'd0, led}, 32'h0);
    applyStimulus(1'b1, 1'b0, 16'h1234);
    waitCycles(8);
    applyStimulus(1'b0, 1'b0, 16'h1234);
    checkOutput("led_commit", {20'd0, led}, 32'h3C5);
    peek(IO_STATUS, rd); checkOutput("led_ready_set", rd, 32'h1);
    waitCycles(8);
    busWrite(IO_LED, 32'h0000_0111);
    peek(IO_STATUS, rd); checkOutput("led_ready_cleared", rd, 32'h0);
    checkOutput("led_hold_after_write", {20'd0, led}, 32'h3C5);

    // 5. coincident events
    applyStimulus(1'b0, 1'b1, 16'h5678);
    waitCycles(6);
    busRead(IO_SW_HI, rd);
    peek(IO_STATUS, rd); checkOutput("pR_vs_read_status", rd, 32'h2);
    peek(IO_SW_HI, rd);  checkOutput("pR_vs_read_sw_hi", rd, 32'h56);
    applyStimulus(1'b0, 1'b0, 16'h5678);
    waitCycles(8);
    busRead(IO_SW_HI, rd);
    busWrite(IO_LED, 32'h0000_03C5);
    applyStimulus(1'b1, 1'b0, 16'h5678);
    waitCycles(6);
    busWrite(IO_LED, 32'h0000_00F0);
    checkOutput("pL_vs_write_led", {20'd0, led}, 32'h3C5);
    peek(IO_LED, rd);    checkOutput("pL_vs_write_pend", rd, 32'h0F0);
    peek(IO_STATUS, rd); checkOutput("pL_vs_write_status", rd, 32'h0);
    applyStimulus(1'b0, 1'b0, 16'h5678);
    waitCycles(8);

    // 6. STATUS write ignored; long hold gives one capture
    busWrite(IO_STATUS, 32'hFFFF_FFFF);
    peek(IO_STATUS, rd); checkOutput("status_write_ignored", rd, 32'h0);
    peek(IO_SW_LO, rd);  checkOutput("sw_lo_after_status_write", rd, 32'h78);
    peek(IO_LED, rd);    checkOutput("pend_after_status_write", rd, 32'h0F0);
    applyStimulus(1'b0, 1'b1, 16'hBEEF);
    waitCycles(7);
    peek(IO_STATUS, rd); checkOutput("long_hold_capture", rd, 32'h2);
    busRead(IO_SW_HI, rd); checkOutput("long_hold_sw_hi", rd, 32'hBE);
    applyStimulus(1'b0, 1'b1, 16'h0F0F);
    waitCycles(990);
    peek(IO_STATUS, rd); checkOutput("long_hold_single", rd, 32'h0);
    peek(IO_SW_LO, rd);  checkOutput("long_hold_sw_lo", rd, 32'hEF);
    applyStimulus(1'b0, 1'b0, 16'h0F0F);
    waitCycles(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
